// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: serve/play/point/over flow, edge miss detection and
// per-player scoring for the ball/paddle datapath and score display.
module pong_match_ctrl #(
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int WIN_SCORE    = 9,
    parameter int MISS_X_L     = 2,
    parameter int MISS_X_R     = 630
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       refr_tick,
    input  logic       btn_start,
    input  logic [9:0] ball_x,
    output logic       ball_en,
    output logic       ball_reset,
    output logic       serve_dir,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       game_over,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_PLAY  = 3'd2,
        S_POINT = 3'd3,
        S_OVER  = 3'd4
    } state_t;

    localparam logic [7:0] L_SERVE_LAST = 8'(SERVE_FRAMES - 1);
    localparam logic [7:0] L_POINT_LAST = 8'(POINT_FRAMES - 1);
    localparam logic [3:0] L_WIN        = 4'(WIN_SCORE);
    localparam logic [9:0] L_MISS_L     = 10'(MISS_X_L);
    localparam logic [9:0] L_MISS_R     = 10'(MISS_X_R);

    state_t     r_state;
    logic [7:0] r_cnt;
    logic       r_start_q;
    logic       r_ball_en;
    logic       r_ball_reset;
    logic       r_serve_dir;
    logic [3:0] r_score_l;
    logic [3:0] r_score_r;
    logic       r_game_over;

    logic       w_start_pe;

    assign w_start_pe = btn_start & ~r_start_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_cnt        <= 8'd0;
            r_start_q    <= 1'b0;
            r_ball_en    <= 1'b0;
            r_ball_reset <= 1'b0;
            r_serve_dir  <= 1'b1;
            r_score_l    <= 4'd0;
            r_score_r    <= 4'd0;
            r_game_over  <= 1'b0;
        end else begin
            r_start_q    <= btn_start;
            r_ball_reset <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_pe) begin
                        r_state      <= S_SERVE;
                        r_ball_reset <= 1'b1;
                        r_cnt        <= 8'd0;
                    end
                end
                S_SERVE: begin
                    if (refr_tick) begin
                        if (r_cnt == L_SERVE_LAST) begin
                            r_state   <= S_PLAY;
                            r_ball_en <= 1'b1;
                            r_cnt     <= 8'd0;
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_PLAY: begin
                    // Serve goes toward the player who just conceded.
                    if (ball_x <= L_MISS_L) begin
                        if (r_score_r < L_WIN) r_score_r <= r_score_r + 4'd1;
                        r_serve_dir <= 1'b0;
                        r_state     <= S_POINT;
                        r_ball_en   <= 1'b0;
                        r_cnt       <= 8'd0;
                    end else if (ball_x >= L_MISS_R) begin
                        if (r_score_l < L_WIN) r_score_l <= r_score_l + 4'd1;
                        r_serve_dir <= 1'b1;
                        r_state     <= S_POINT;
                        r_ball_en   <= 1'b0;
                        r_cnt       <= 8'd0;
                    end
                end
                S_POINT: begin
                    if (refr_tick) begin
                        if (r_cnt == L_POINT_LAST) begin
                            r_cnt <= 8'd0;
                            if (r_score_l == L_WIN || r_score_r == L_WIN) begin
                                r_state     <= S_OVER;
                                r_game_over <= 1'b1;
                            end else begin
                                r_state      <= S_SERVE;
                                r_ball_reset <= 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 8'd1;
                        end
                    end
                end
                S_OVER: begin
                    if (w_start_pe) begin
                        r_score_l    <= 4'd0;
                        r_score_r    <= 4'd0;
                        r_serve_dir  <= 1'b1;
                        r_game_over  <= 1'b0;
                        r_state      <= S_SERVE;
                        r_ball_reset <= 1'b1;
                        r_cnt        <= 8'd0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_ball_en   <= 1'b0;
                    r_game_over <= 1'b0;
                    r_cnt       <= 8'd0;
                end
            endcase
        end
    end

    assign ball_en    = r_ball_en;
    assign ball_reset = r_ball_reset;
    assign serve_dir  = r_serve_dir;
    assign score_l    = r_score_l;
    assign score_r    = r_score_r;
    assign game_over  = r_game_over;
    assign state_o    = r_state;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: expected state transitions are queued as stimulus
// is driven and compared by a monitor whenever state_o changes.
module tb_pong_match_ctrl;

    localparam int WIN   = 4;
    localparam int SERVE = 60;
    localparam int POINT = 90;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       refr_tick = 1'b0;
    logic       btn_start = 1'b0;
    logic [9:0] ball_x = 10'd320;
    logic       ball_en, ball_reset, serve_dir, game_over;
    logic [3:0] score_l, score_r;
    logic [2:0] state_o;

    typedef struct packed {
        logic [2:0] st;
        logic [3:0] l;
        logic [3:0] r;
        logic       dir;
        logic       go;
        logic       en;
        logic       br;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   n_br   = 0;
    logic [3:0] m_l = 4'd0;
    logic [3:0] m_r = 4'd0;
    logic       m_dir = 1'b1;
    logic [2:0] prev_state = 3'd0;

    pong_match_ctrl #(
        .SERVE_FRAMES(SERVE),
        .POINT_FRAMES(POINT),
        .WIN_SCORE(WIN),
        .MISS_X_L(2),
        .MISS_X_R(630)
    ) dut (
        .clk(clk), .rst(rst), .refr_tick(refr_tick), .btn_start(btn_start),
        .ball_x(ball_x), .ball_en(ball_en), .ball_reset(ball_reset),
        .serve_dir(serve_dir), .score_l(score_l), .score_r(score_r),
        .game_over(game_over), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Monitor: each state change must match the next queued expectation;
    // ball_reset may only be high on the first SERVE cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t got;
        got = '{st: state_o, l: score_l, r: score_r, dir: serve_dir,
                go: game_over, en: ball_en, br: ball_reset};
        if (ball_reset === 1'b1) n_br++;
        if (state_o !== prev_state) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_transition: got %h, nothing expected", got);
            end else begin
                e = exp_q.pop_front();
                if (got !== e) begin
                    errors++;
                    $display("FAIL transition: got st=%0d l=%0d r=%0d dir=%b go=%b en=%b br=%b, want st=%0d l=%0d r=%0d dir=%b go=%b en=%b br=%b",
                             got.st, got.l, got.r, got.dir, got.go, got.en, got.br,
                             e.st, e.l, e.r, e.dir, e.go, e.en, e.br);
                end
            end
            prev_state = state_o;
        end else if (ball_reset !== 1'b0) begin
            checks++;
            errors++;
            $display("FAIL ball_reset_extra: got %b in state %0d, want 0", ball_reset, state_o);
        end
    end

    task automatic push_exp(input logic [2:0] st);
        exp_q.push_back('{st: st, l: m_l, r: m_r, dir: m_dir, go: (st == 3'd4),
                          en: (st == 3'd2), br: (st == 3'd1)});
    endtask

    task automatic tick();
        @(negedge clk) refr_tick = 1'b1;
        @(negedge clk) refr_tick = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic press();
        @(negedge clk) btn_start = 1'b1;
        @(negedge clk) btn_start = 1'b0;
    endtask

    task automatic go_play();
        repeat (SERVE - 1) tick();
        push_exp(3'd2);
        tick();
    endtask

    task automatic miss(input logic [9:0] x, input int hold);
        if (x >= 10'd630) begin
            m_l = m_l + 4'd1;
            m_dir = 1'b1;
        end else begin
            m_r = m_r + 4'd1;
            m_dir = 1'b0;
        end
        push_exp(3'd3);
        @(negedge clk) ball_x = x;
        repeat (hold) @(negedge clk);
        ball_x = 10'd320;
    endtask

    task automatic expire_point();
        repeat (POINT - 1) tick();
        if (m_l == 4'(WIN) || m_r == 4'(WIN)) push_exp(3'd4);
        else push_exp(3'd1);
        tick();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({state_o, ball_en, ball_reset, serve_dir, score_l, score_r, game_over} !==
            {3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values: got st=%0d en=%b br=%b dir=%b l=%0d r=%0d go=%b, want 0 0 0 1 0 0 0",
                     state_o, ball_en, ball_reset, serve_dir, score_l, score_r, game_over);
        end
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL idle_hold: got state %0d, want 0", state_o);
        end
    endtask

    task automatic test_start_serve();
        push_exp(3'd1);
        press();
        @(negedge clk);
        checks++;
        if (n_br != 1) begin
            errors++;
            $display("FAIL serve_reset_pulse: got %0d pulses, want 1", n_br);
        end
        repeat (SERVE - 1) tick();
        checks++;
        if (state_o !== 3'd1 || ball_en !== 1'b0) begin
            errors++;
            $display("FAIL serve_hold: got st=%0d en=%b after 59 ticks, want 1 0", state_o, ball_en);
        end
        push_exp(3'd2);
        tick();
        checks++;
        if (state_o !== 3'd2 || ball_en !== 1'b1) begin
            errors++;
            $display("FAIL serve_release: got st=%0d en=%b, want 2 1", state_o, ball_en);
        end
    endtask

    task automatic test_miss_left();
        int br0;
        miss(10'd1, 20);
        checks++;
        if (score_r !== 4'd1 || score_l !== 4'd0 || serve_dir !== 1'b0 || state_o !== 3'd3) begin
            errors++;
            $display("FAIL miss_left: got r=%0d l=%0d dir=%b st=%0d, want 1 0 0 3",
                     score_r, score_l, serve_dir, state_o);
        end
        br0 = n_br;
        expire_point();
        checks++;
        if (state_o !== 3'd1 || n_br != br0 + 1) begin
            errors++;
            $display("FAIL point_to_serve: got st=%0d pulses=%0d, want 1 %0d", state_o, n_br - br0, 1);
        end
    endtask

    task automatic test_ignore_start();
        repeat (30) tick();
        press();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL start_in_serve: got state %0d, want 1", state_o);
        end
        repeat (29) tick();
        push_exp(3'd2);
        tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL serve_count_after_press: got state %0d, want 2", state_o);
        end
        press();
        repeat (5) @(negedge clk);
        checks++;
        if (state_o !== 3'd2 || score_l !== m_l || score_r !== m_r) begin
            errors++;
            $display("FAIL start_in_play: got st=%0d l=%0d r=%0d, want 2 %0d %0d",
                     state_o, score_l, score_r, m_l, m_r);
        end
    endtask

    task automatic test_win();
        @(negedge clk) ball_x = 10'd3;
        repeat (4) @(negedge clk);
        ball_x = 10'd629;
        repeat (4) @(negedge clk);
        ball_x = 10'd320;
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL near_edge_no_miss: got state %0d, want 2", state_o);
        end
        for (int k = 1; k <= WIN; k++) begin
            miss((k == 1) ? 10'd630 : 10'd635, 6);
            checks++;
            if (score_l !== 4'(k) || serve_dir !== 1'b1) begin
                errors++;
                $display("FAIL miss_right_%0d: got l=%0d dir=%b, want %0d 1", k, score_l, serve_dir, k);
            end
            expire_point();
            if (k < WIN) go_play();
        end
        checks++;
        if (state_o !== 3'd4 || game_over !== 1'b1 || ball_en !== 1'b0) begin
            errors++;
            $display("FAIL game_over: got st=%0d go=%b en=%b, want 4 1 0", state_o, game_over, ball_en);
        end
        repeat (5) tick();
        checks++;
        if (score_l !== 4'(WIN) || score_r !== 4'd1) begin
            errors++;
            $display("FAIL over_hold: got l=%0d r=%0d, want %0d 1", score_l, score_r, WIN);
        end
    endtask

    task automatic test_restart();
        int br0;
        br0 = n_br;
        m_l = 4'd0;
        m_r = 4'd0;
        m_dir = 1'b1;
        push_exp(3'd1);
        @(negedge clk) begin
            btn_start = 1'b1;
            refr_tick = 1'b1;
        end
        @(negedge clk) refr_tick = 1'b0;
        repeat (99) @(negedge clk);
        checks++;
        if (state_o !== 3'd1 || n_br != br0 + 1 || score_l !== 4'd0 || score_r !== 4'd0 || serve_dir !== 1'b1) begin
            errors++;
            $display("FAIL restart: got st=%0d pulses=%0d l=%0d r=%0d dir=%b, want 1 1 0 0 1",
                     state_o, n_br - br0, score_l, score_r, serve_dir);
        end
        btn_start = 1'b0;
        repeat (SERVE - 1) tick();
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL entry_tick_not_counted: got state %0d after 59 ticks, want 1", state_o);
        end
        push_exp(3'd2);
        tick();
        checks++;
        if (state_o !== 3'd2) begin
            errors++;
            $display("FAIL restart_release: got state %0d, want 2", state_o);
        end
    endtask

    task automatic test_rst_mid_point();
        for (int k = 0; k < 3; k++) begin
            miss(10'd635, 4);
            if (k < 2) begin
                expire_point();
                go_play();
            end
        end
        repeat (10) tick();
        checks++;
        if (state_o !== 3'd3 || score_l !== 4'd3) begin
            errors++;
            $display("FAIL pre_reset: got st=%0d l=%0d, want 3 3", state_o, score_l);
        end
        m_l = 4'd0;
        m_r = 4'd0;
        m_dir = 1'b1;
        push_exp(3'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({state_o, ball_en, ball_reset, serve_dir, score_l, score_r, game_over} !==
            {3'd0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset: got st=%0d en=%b br=%b dir=%b l=%0d r=%0d go=%b, want 0 0 0 1 0 0 0",
                     state_o, ball_en, ball_reset, serve_dir, score_l, score_r, game_over);
        end
        @(negedge clk) rst = 1'b0;
        repeat (10) tick();
        checks++;
        if (state_o !== 3'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got state %0d, want 0", state_o);
        end
        push_exp(3'd1);
        press();
        @(negedge clk);
        checks++;
        if (state_o !== 3'd1) begin
            errors++;
            $display("FAIL post_reset_start: got state %0d, want 1", state_o);
        end
    endtask

    initial begin
        test_reset();
        test_start_serve();
        test_miss_left();
        test_ignore_start();
        test_win();
        test_restart();
        test_rst_mid_point();
        repeat (4) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_transitions: got %0d unconsumed, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
